if_fetch_unit: RTL and testbench

Instruction fetch stage of the RV32 core. It owns the program counter and issues single-outstanding requests on the instruction bus. It delivers fetched instructions, with their PC, as registered outputs that feed the IF/ID pipeline register's data input. It honours the pipeline hold flag through a one-entry skid buffer and applies jump redirects, which take priority over everything else.

---
 rtl/if_fetch_unit.sv | 125 ++++++++++++
 tb/tb_if_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage for the RV32 core.
// Owns the PC and keeps at most one request outstanding on the instruction bus.
// Delivers registered {valid, pc, instruction} to the IF/ID register.
// A one-entry skid buffer absorbs an ack that lands while the pipeline is held.
// A jump redirect overrides hold, ack and skid state.
module if_fetch_unit #(
  parameter int                   DataWidth = 32,
  parameter logic [DataWidth-1:0] ResetPC   = '0,
  parameter logic [DataWidth-1:0] NopInst   = DataWidth'(32'h0000_0013)
) (
  input  logic                 sys_clk,
  input  logic                 sys_arstn,
  input  logic                 flag_hold,
  input  logic                 jump_en,
  input  logic [DataWidth-1:0] jump_addr,
  output logic                 ibus_req,
  output logic [DataWidth-1:0] ibus_addr,
  input  logic                 ibus_ack,
  input  logic [DataWidth-1:0] ibus_rdata,
  output logic                 inst_valid,
  output logic [DataWidth-1:0] inst_pc,
  output logic [DataWidth-1:0] inst_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    STALL = 2'd3
  } state_t;

  localparam logic [DataWidth-1:0] PcStep    = DataWidth'(4);
  localparam logic [DataWidth-1:0] AlignMask = ~DataWidth'(3);

  state_t               state;
  logic [DataWidth-1:0] req_addr;
  logic [DataWidth-1:0] pending_pc;
  logic                 skid_valid;
  logic [DataWidth-1:0] skid_pc;
  logic [DataWidth-1:0] skid_data;
  logic [DataWidth-1:0] jump_target;

  // Redirect targets are always word aligned.
  assign jump_target = jump_addr & AlignMask;

  // In DRAIN req_addr is left untouched, so the bus keeps seeing the stale address.
  assign ibus_addr = req_addr;

  // Fetch controller: state, PC, skid buffer and the registered output stage.
  always_ff @(posedge sys_clk) begin
    if (!sys_arstn) begin
      state      <= IDLE;
      ibus_req   <= 1'b0;
      req_addr   <= ResetPC;
      pending_pc <= ResetPC;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_data  <= NopInst;
      inst_valid <= 1'b0;
      inst_pc    <= '0;
      inst_data  <= NopInst;
    end else if (jump_en && (state != IDLE)) begin
      // A redirect squashes the output and the skid contents even under hold.
      inst_valid <= 1'b0;
      inst_pc    <= '0;
      inst_data  <= NopInst;
      skid_valid <= 1'b0;
      ibus_req   <= 1'b1;
      if (((state == FETCH) || (state == DRAIN)) && !ibus_ack) begin
        // The old request must finish first, so the target waits in pending_pc.
        pending_pc <= jump_target;
        state      <= DRAIN;
      end else begin
        // Nothing left outstanding: any word acked in this cycle is dropped.
        req_addr <= jump_target;
        state    <= FETCH;
      end
    end else begin
      case (state)
        IDLE: begin
          ibus_req <= 1'b1;
          state    <= FETCH;
        end
        FETCH: begin
          if (ibus_ack) begin
            req_addr <= req_addr + PcStep;
            if (!flag_hold) begin
              inst_valid <= 1'b1;
              inst_pc    <= req_addr;
              inst_data  <= ibus_rdata;
            end else begin
              skid_valid <= 1'b1;
              skid_pc    <= req_addr;
              skid_data  <= ibus_rdata;
              ibus_req   <= 1'b0;
              state      <= STALL;
            end
          end
        end
        STALL: begin
          // No request is issued here, so an ack in this state is spurious.
          if (!flag_hold) begin
            inst_valid <= skid_valid;
            inst_pc    <= skid_pc;
            inst_data  <= skid_data;
            skid_valid <= 1'b0;
            ibus_req   <= 1'b1;
            state      <= FETCH;
          end
        end
        DRAIN: begin
          if (ibus_ack) begin
            req_addr <= pending_pc;
            state    <= FETCH;
          end
        end
        default: begin
          ibus_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit.
// A scoreboard queue holds expected {pc, data} deliveries; a second instance covers PC wrap.
module tb_if_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        sys_arstn;
  logic        flag_hold;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  logic        w_arstn;
  logic        w_ack;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_data;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        prev_valid;
  logic [31:0] prev_pc;

  // Clock generator.
  always #5 sys_clk = ~sys_clk;

  // Bus model: every word is its address XOR a fixed key.
  assign ibus_rdata = ibus_addr ^ KEY;
  assign w_rdata    = w_addr ^ KEY;

  if_fetch_unit #(
    .DataWidth(32),
    .ResetPC  (32'h0000_0000),
    .NopInst  (NOP)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_arstn (sys_arstn),
    .flag_hold (flag_hold),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .ibus_req  (ibus_req),
    .ibus_addr (ibus_addr),
    .ibus_ack  (ibus_ack),
    .ibus_rdata(ibus_rdata),
    .inst_valid(inst_valid),
    .inst_pc   (inst_pc),
    .inst_data (inst_data)
  );

  if_fetch_unit #(
    .DataWidth(32),
    .ResetPC  (32'hFFFF_FFFC),
    .NopInst  (NOP)
  ) u_wrap (
    .sys_clk   (sys_clk),
    .sys_arstn (w_arstn),
    .flag_hold (flag_hold),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .ibus_req  (w_req),
    .ibus_addr (w_addr),
    .ibus_ack  (w_ack),
    .ibus_rdata(w_rdata),
    .inst_valid(w_valid),
    .inst_pc   (w_pc),
    .inst_data (w_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, optionally push an expected delivery, clock, then
  // pop the scoreboard when the DUT presents a new valid instruction.
  task automatic cycle(input logic hold, input logic jen, input logic [31:0] jaddr,
                       input logic ack, input logic push, input logic [31:0] exp_pc);
    exp_t e;
    flag_hold = hold;
    jump_en   = jen;
    jump_addr = jaddr;
    ibus_ack  = ack;
    if (push) begin
      e.pc   = exp_pc;
      e.data = exp_pc ^ KEY;
      sb_q.push_back(e);
    end
    @(posedge sys_clk);
    #1;
    if (inst_valid && (!prev_valid || (inst_pc != prev_pc))) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h data %h, expected no delivery", inst_pc, inst_data);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_pc", inst_pc, e.pc);
        check_eq("sb_data", inst_data, e.data);
      end
    end
    prev_valid = inst_valid;
    prev_pc    = inst_pc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   32'(ibus_req),   32'h0);
    check_eq({tag, "_addr"},  ibus_addr,       32'h0);
    check_eq({tag, "_valid"}, 32'(inst_valid), 32'h0);
    check_eq({tag, "_pc"},    inst_pc,         32'h0);
    check_eq({tag, "_data"},  inst_data,       NOP);
  endtask

  initial begin
    sys_arstn  = 1'b0;
    flag_hold  = 1'b0;
    jump_en    = 1'b0;
    jump_addr  = 32'h0;
    ibus_ack   = 1'b0;
    w_arstn    = 1'b0;
    w_ack      = 1'b0;
    prev_valid = 1'b0;
    prev_pc    = 32'h0;

    // Reset state
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_reset_outputs("rst");

    // Release: IDLE for one cycle, then the first request
    sys_arstn = 1'b1;
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("first_req", 32'(ibus_req), 32'h1);

    // Back-to-back stream with ack every cycle
    for (int i = 0; i < 2; i++) begin
      check_eq("stream_addr", ibus_addr, 32'(4 * i));
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'(4 * i));
      check_eq("stream_valid", 32'(inst_valid), 32'h1);
    end
    check_eq("stream_addr", ibus_addr, 32'h8);

    // Hold for three cycles while the ack for addr 8 lands in the skid
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8);
    check_eq("hold_pc", inst_pc, 32'h4);
    check_eq("hold_req", 32'(ibus_req), 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("hold_pc", inst_pc, 32'h4);
    check_eq("hold_req", 32'(ibus_req), 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("spurious_pc", inst_pc, 32'h4);
    check_eq("spurious_valid", 32'(inst_valid), 32'h1);
    check_eq("spurious_req", 32'(ibus_req), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("resume_pc", inst_pc, 32'h8);
    check_eq("resume_req", 32'(ibus_req), 32'h1);
    check_eq("resume_addr", ibus_addr, 32'hC);

    // Jump taken from STALL (skid holds addr 12, which must be squashed)
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("stall2_req", 32'(ibus_req), 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 32'h0);
    check_eq("jstall_valid", 32'(inst_valid), 32'h0);
    check_eq("jstall_pc", inst_pc, 32'h0);
    check_eq("jstall_data", inst_data, NOP);
    check_eq("jstall_addr", ibus_addr, 32'h100);
    check_eq("jstall_req", 32'(ibus_req), 32'h1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100);

    // Jump while the request to 0x104 is outstanding: drain first
    cycle(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0);
    check_eq("drain_valid", 32'(inst_valid), 32'h0);
    check_eq("drain_addr", ibus_addr, 32'h104);
    check_eq("drain_req", 32'(ibus_req), 32'h1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("drain_addr", ibus_addr, 32'h104);
    check_eq("drain_req", 32'(ibus_req), 32'h1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("drained_addr", ibus_addr, 32'h200);
    check_eq("drained_valid", 32'(inst_valid), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);

    // A second jump during DRAIN replaces the pending target
    cycle(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0);
    check_eq("redrain_addr", ibus_addr, 32'h204);
    cycle(1'b0, 1'b1, 32'h0000_0403, 1'b0, 1'b0, 32'h0);
    check_eq("redrain_addr", ibus_addr, 32'h204);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("redrained_addr", ibus_addr, 32'h400);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h400);

    // Hold in FETCH without an ack leaves the outputs alone
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("fhold_pc", inst_pc, 32'h400);
    check_eq("fhold_valid", 32'(inst_valid), 32'h1);
    check_eq("fhold_req", 32'(ibus_req), 32'h1);
    check_eq("fhold_addr", ibus_addr, 32'h404);

    // Jump, ack and hold in the same cycle
    cycle(1'b1, 1'b1, 32'h0000_0500, 1'b1, 1'b0, 32'h0);
    check_eq("jack_valid", 32'(inst_valid), 32'h0);
    check_eq("jack_pc", inst_pc, 32'h0);
    check_eq("jack_data", inst_data, NOP);
    check_eq("jack_addr", ibus_addr, 32'h500);
    check_eq("jack_req", 32'(ibus_req), 32'h1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h500);

    // Reset in the middle of a stream
    sys_arstn = 1'b0;
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_reset_outputs("midrst");

    // Wrap-around on the instance reset to 0xFFFF_FFFC
    w_arstn = 1'b1;
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("wrap_req", 32'(w_req), 32'h1);
    check_eq("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    w_ack = 1'b1;
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("wrap_pc0", w_pc, 32'hFFFF_FFFC);
    check_eq("wrap_data0", w_data, 32'hFFFF_FFFC ^ KEY);
    check_eq("wrap_valid0", 32'(w_valid), 32'h1);
    check_eq("wrap_addr1", w_addr, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("wrap_pc1", w_pc, 32'h0);
    check_eq("wrap_addr2", w_addr, 32'h4);
    w_ack = 1'b0;

    check_eq("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
